// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SETUP   = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5
  } bridge_state_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational AHB address decoder: maps haddr onto an APB slave index
// and flags transfers that cannot be forwarded (out of range, oversize or
// misaligned for their size).
module apb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                NUM_SLV  = 4,
  parameter int                IDX_W    = 2,
  parameter logic [ADDR_W-1:0] SLV_BASE = 32'h4000_0000,
  parameter logic [ADDR_W-1:0] SLV_SPAN = 32'h0000_1000
) (
  input  logic [ADDR_W-1:0] i_haddr,
  input  logic [2:0]        i_hsize,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_illegal
);

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_idx_full;
  logic              w_oor;
  logic              w_bad_size;

  // Slave index from offset, range check, and size/alignment legality.
  always_comb begin
    w_off      = i_haddr - SLV_BASE;
    w_idx_full = w_off / SLV_SPAN;
    w_oor      = (i_haddr < SLV_BASE) || (w_idx_full >= ADDR_W'(NUM_SLV));
    w_bad_size = 1'b0;
    case (i_hsize)
      HSIZE_BYTE: w_bad_size = 1'b0;
      HSIZE_HALF: w_bad_size = i_haddr[0];
      HSIZE_WORD: w_bad_size = |i_haddr[1:0];
      default:    w_bad_size = 1'b1;
    endcase
    o_idx     = w_idx_full[IDX_W-1:0];
    o_illegal = w_oor || w_bad_size;
  end

endmodule

// File: rtl/ahb2apb_bridge_core.sv
// AHB-Lite slave to APB3 master bridge. One AHB transfer at a time is
// decoded, then driven through CAPTURE -> SETUP -> ACCESS; the AHB data
// phase is stretched with hready_out until the APB slave responds.
module ahb2apb_bridge_core
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                NUM_SLV  = 4,
  parameter logic [ADDR_W-1:0] SLV_BASE = 32'h4000_0000,
  parameter logic [ADDR_W-1:0] SLV_SPAN = 32'h0000_1000,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready_in,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic [ADDR_W-1:0] paddr,
  output logic [NUM_SLV-1:0] psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  bridge_state_e r_state;
  bridge_state_e w_state_nxt;

  logic [ADDR_W-1:0]  r_haddr;
  logic               r_hwrite;
  logic [IDX_W-1:0]   r_idx;
  logic [TO_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]  r_paddr;
  logic [NUM_SLV-1:0] r_psel;
  logic               r_penable;
  logic               r_pwrite;
  logic [DATA_W-1:0]  r_pwdata;
  logic [DATA_W-1:0]  r_hrdata;

  logic               w_valid;
  logic               w_sample;
  logic               w_done;
  logic               w_timeout_hit;
  logic [IDX_W-1:0]   w_idx;
  logic               w_illegal;
  logic [NUM_SLV-1:0] w_psel_dec;

  apb_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IDX_W),
    .SLV_BASE(SLV_BASE),
    .SLV_SPAN(SLV_SPAN)
  ) u_decode (
    .i_haddr  (haddr),
    .i_hsize  (hsize),
    .o_idx    (w_idx),
    .o_illegal(w_illegal)
  );

  assign w_valid       = hsel & hready_in & htrans[1];
  assign w_done        = (r_state == ST_ACCESS) & pready & ~pslverr;
  assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  assign paddr   = r_paddr;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign pwdata  = r_pwdata;
  // Read data passes straight through in the completing cycle, else holds.
  assign hrdata  = w_done ? prdata : r_hrdata;

  // One-hot slave select from the latched index.
  always_comb begin
    w_psel_dec        = '0;
    w_psel_dec[r_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic plus AHB response and address-phase sampling strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    hready_out  = 1'b1;
    hresp       = HRESP_OKAY;
    case (r_state)
      ST_IDLE: begin
        w_sample = w_valid;
        if (w_valid) w_state_nxt = w_illegal ? ST_ERR1 : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        hready_out  = 1'b0;
        w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        hready_out  = 1'b0;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        hready_out = pready & ~pslverr;
        if (pready && pslverr) begin
          w_state_nxt = ST_ERR1;
        end else if (pready) begin
          // Completing cycle doubles as an address phase for back-to-back.
          w_sample    = w_valid;
          w_state_nxt = w_valid ? (w_illegal ? ST_ERR1 : ST_CAPTURE) : ST_IDLE;
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_ERR1;
        end
      end
      ST_ERR1: begin
        hready_out  = 1'b0;
        hresp       = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        hresp    = HRESP_ERROR;
        w_sample = w_valid;
        if (w_valid) w_state_nxt = w_illegal ? ST_ERR1 : ST_CAPTURE;
        else         w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address-phase capture, APB bus drive, wait-state counter and read data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_haddr   <= '0;
      r_hwrite  <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_hrdata  <= '0;
    end else begin
      if (w_sample) begin
        r_haddr  <= haddr;
        r_hwrite <= hwrite;
        r_idx    <= w_idx;
      end
      if (r_state == ST_CAPTURE) begin
        r_paddr   <= r_haddr;
        r_pwrite  <= r_hwrite;
        r_psel    <= w_psel_dec;
        r_penable <= 1'b0;
        if (r_hwrite) r_pwdata <= hwdata;
      end
      if (r_state == ST_SETUP) r_penable <= 1'b1;
      if ((r_state == ST_ACCESS) && (pready || w_timeout_hit)) begin
        r_psel    <= '0;
        r_penable <= 1'b0;
      end
      if ((r_state == ST_ACCESS) && !pready && !w_timeout_hit)
        r_cnt <= r_cnt + TO_W'(1);
      else
        r_cnt <= '0;
      if (w_done) r_hrdata <= prdata;
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge_core.sv
// Directed testbench for ahb2apb_bridge_core with hand-computed expectations.
module tb_ahb2apb_bridge_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] paddr;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Single-slave AHB system: bus HREADY is the bridge's own HREADYOUT.
  assign hready_in = hready_out;

  ahb2apb_bridge_core dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = s;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc(); #1;
    n_checks++;
    if ({psel, penable, pwrite, hresp, hready_out} !== 9'h001) begin
      n_errors++; $display("FAIL reset_ctrl: got %h expected 001", {psel, penable, pwrite, hresp, hready_out});
    end
    n_checks++;
    if ({paddr, pwdata, hrdata} !== 96'h0) begin
      n_errors++; $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, hrdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    pready = 1'b1; pslverr = 1'b0;
    addr_phase(32'h4000_1004, 1'b1, 3'd2);
    cyc(); idle_bus(); hwdata = 32'hDEAD_BEEF; #1;
    n_checks++;
    if ({psel, penable, hready_out} !== 6'b0000_0_0) begin
      n_errors++; $display("FAIL write_capture: got %b expected 000000", {psel, penable, hready_out});
    end
    cyc(); #1;
    n_checks++;
    if ({psel, penable, pwrite, hready_out} !== 7'b0010_0_1_0) begin
      n_errors++; $display("FAIL write_setup: got %b expected 0010010", {psel, penable, pwrite, hready_out});
    end
    n_checks++;
    if (paddr !== 32'h4000_1004) begin
      n_errors++; $display("FAIL write_paddr: got %h expected 40001004", paddr);
    end
    n_checks++;
    if (pwdata !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL write_pwdata: got %h expected deadbeef", pwdata);
    end
    cyc(); #1;
    n_checks++;
    if ({psel, penable, hready_out, hresp} !== 8'b0010_1_1_00) begin
      n_errors++; $display("FAIL write_access: got %b expected 00101100", {psel, penable, hready_out, hresp});
    end
    cyc(); #1;
    n_checks++;
    if ({psel, penable, hready_out, hresp} !== 8'b0000_0_1_00) begin
      n_errors++; $display("FAIL write_after: got %b expected 00000100", {psel, penable, hready_out, hresp});
    end
  endtask

  task automatic test_read_wait();
    pready = 1'b0; prdata = 32'h1234_5678;
    addr_phase(32'h4000_3000, 1'b0, 3'd2);
    cyc(); idle_bus(); #1;
    n_checks++;
    if (hready_out !== 1'b0) begin
      n_errors++; $display("FAIL read_capture: got %b expected 0", hready_out);
    end
    cyc(); #1;
    n_checks++;
    if ({psel, penable, pwrite, hready_out} !== 7'b1000_0_0_0) begin
      n_errors++; $display("FAIL read_setup: got %b expected 1000000", {psel, penable, pwrite, hready_out});
    end
    n_checks++;
    if (paddr !== 32'h4000_3000) begin
      n_errors++; $display("FAIL read_paddr: got %h expected 40003000", paddr);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      n_checks++;
      if ({psel, penable, hready_out} !== 6'b1000_1_0) begin
        n_errors++; $display("FAIL read_wait%0d: got %b expected 100010", i, {psel, penable, hready_out});
      end
    end
    cyc(); pready = 1'b1; #1;
    n_checks++;
    if ({hready_out, hresp, hrdata} !== {1'b1, 2'b00, 32'h1234_5678}) begin
      n_errors++; $display("FAIL read_done: got %h expected 412345678", {hready_out, hresp, hrdata});
    end
    cyc(); pready = 1'b0; prdata = 32'h0; #1;
    n_checks++;
    if ({psel, hrdata} !== {4'b0000, 32'h1234_5678}) begin
      n_errors++; $display("FAIL read_hold: got %h expected 012345678", {psel, hrdata});
    end
  endtask

  task automatic test_slverr();
    pready = 1'b0; pslverr = 1'b0;
    addr_phase(32'h4000_0000, 1'b1, 3'd2);
    cyc(); idle_bus(); hwdata = 32'h0000_0001;
    cyc();
    cyc(); pready = 1'b1; pslverr = 1'b1; #1;
    n_checks++;
    if ({psel, penable, hready_out, hresp} !== 8'b0001_1_0_00) begin
      n_errors++; $display("FAIL slverr_access: got %b expected 00011000", {psel, penable, hready_out, hresp});
    end
    cyc(); pready = 1'b0; pslverr = 1'b0; #1;
    n_checks++;
    if ({psel, penable, hready_out, hresp} !== 8'b0000_0_0_01) begin
      n_errors++; $display("FAIL slverr_err1: got %b expected 00000001", {psel, penable, hready_out, hresp});
    end
    cyc(); #1;
    n_checks++;
    if ({psel, penable, hready_out, hresp} !== 8'b0000_0_1_01) begin
      n_errors++; $display("FAIL slverr_err2: got %b expected 00000101", {psel, penable, hready_out, hresp});
    end
    cyc(); #1;
    n_checks++;
    if ({hready_out, hresp} !== 3'b1_00) begin
      n_errors++; $display("FAIL slverr_idle: got %b expected 100", {hready_out, hresp});
    end
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [4];
    logic [2:0]  sizes [4];
    addrs = '{32'h4000_4000, 32'h3FFF_FFFC, 32'h4000_0000, 32'h4000_0002};
    sizes = '{3'd2, 3'd2, 3'd3, 3'd2};
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_phase(addrs[i], 1'b0, sizes[i]);
      cyc(); idle_bus(); #1;
      n_checks++;
      if ({psel, penable, hready_out, hresp} !== 8'b0000_0_0_01) begin
        n_errors++; $display("FAIL decode%0d_err1: got %b expected 00000001", i, {psel, penable, hready_out, hresp});
      end
      cyc(); #1;
      n_checks++;
      if ({psel, penable, hready_out, hresp} !== 8'b0000_0_1_01) begin
        n_errors++; $display("FAIL decode%0d_err2: got %b expected 00000101", i, {psel, penable, hready_out, hresp});
      end
      cyc(); #1;
      n_checks++;
      if ({psel, penable, hready_out, hresp} !== 8'b0000_0_1_00) begin
        n_errors++; $display("FAIL decode%0d_idle: got %b expected 00000100", i, {psel, penable, hready_out, hresp});
      end
    end
    pready = 1'b0;
  endtask

  task automatic test_timeout();
    pready = 1'b0;
    addr_phase(32'h4000_2000, 1'b0, 3'd2);
    cyc(); idle_bus();
    cyc();
    for (int i = 1; i <= 16; i++) begin
      cyc(); #1;
      n_checks++;
      if ({psel, penable, hready_out, hresp} !== 8'b0100_1_0_00) begin
        n_errors++; $display("FAIL timeout_wait%0d: got %b expected 01001000", i, {psel, penable, hready_out, hresp});
      end
    end
    cyc(); #1;
    n_checks++;
    if ({psel, penable, hready_out, hresp} !== 8'b0000_0_0_01) begin
      n_errors++; $display("FAIL timeout_err1: got %b expected 00000001", {psel, penable, hready_out, hresp});
    end
    cyc(); #1;
    n_checks++;
    if ({psel, penable, hready_out, hresp} !== 8'b0000_0_1_01) begin
      n_errors++; $display("FAIL timeout_err2: got %b expected 00000101", {psel, penable, hready_out, hresp});
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    pready = 1'b1;
    addr_phase(32'h4000_0004, 1'b1, 3'd2);
    cyc(); idle_bus(); hwdata = 32'hAAAA_5555;
    cyc();
    cyc(); addr_phase(32'h4000_1008, 1'b0, 3'd2); #1;
    n_checks++;
    if ({psel, penable, hready_out} !== 6'b0001_1_1) begin
      n_errors++; $display("FAIL b2b_first_done: got %b expected 000111", {psel, penable, hready_out});
    end
    cyc(); idle_bus(); pready = 1'b0; hwdata = 32'h0; #1;
    n_checks++;
    if ({psel, penable, hready_out} !== 6'b0000_0_0) begin
      n_errors++; $display("FAIL b2b_capture: got %b expected 000000", {psel, penable, hready_out});
    end
    cyc(); #1;
    n_checks++;
    if ({psel, pwrite, paddr} !== {4'b0010, 1'b0, 32'h4000_1008}) begin
      n_errors++; $display("FAIL b2b_setup: got %h expected 0440001008", {psel, pwrite, paddr});
    end
    n_checks++;
    if (pwdata !== 32'hAAAA_5555) begin
      n_errors++; $display("FAIL b2b_pwdata: got %h expected aaaa5555", pwdata);
    end
    cyc(); pready = 1'b1; prdata = 32'hCAFE_F00D; #1;
    n_checks++;
    if ({hready_out, hrdata} !== {1'b1, 32'hCAFE_F00D}) begin
      n_errors++; $display("FAIL b2b_read: got %h expected 1cafef00d", {hready_out, hrdata});
    end
    cyc(); pready = 1'b0; prdata = 32'h0; #1;
  endtask

  task automatic test_rst_mid();
    pready = 1'b0;
    addr_phase(32'h4000_1000, 1'b1, 3'd2);
    cyc(); idle_bus(); hwdata = 32'h5A5A_5A5A;
    cyc();
    cyc(); #1;
    n_checks++;
    if ({psel, penable, hrdata} !== {4'b0010, 1'b1, 32'hCAFE_F00D}) begin
      n_errors++; $display("FAIL rstmid_pre: got %h expected 05cafef00d", {psel, penable, hrdata});
    end
    rst = 1'b1;
    cyc(); #1;
    n_checks++;
    if ({psel, penable, pwrite, hresp, hready_out} !== 9'h001) begin
      n_errors++; $display("FAIL rstmid_ctrl: got %h expected 001", {psel, penable, pwrite, hresp, hready_out});
    end
    n_checks++;
    if ({paddr, pwdata, hrdata} !== 96'h0) begin
      n_errors++; $display("FAIL rstmid_data: got %h expected 0", {paddr, pwdata, hrdata});
    end
    rst = 1'b0;
    cyc(); #1;
    n_checks++;
    if ({psel, penable, hready_out, hresp} !== 8'b0000_0_1_00) begin
      n_errors++; $display("FAIL rstmid_after: got %b expected 00000100", {psel, penable, hready_out, hresp});
    end
  endtask

  initial begin
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_decode_err();
    test_timeout();
    test_back_to_back();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
